// File: rtl/mm_responder_if.sv
// Line-fill / write-back port between the cache initiator and the memory responder.
interface mm_responder_if;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned CNT_W  = 16;

    logic [ADDR_W-1:0] a;
    logic              read;
    logic              write;
    logic [LINE_W-1:0] wd;
    logic [LINE_W-1:0] rd;
    logic              valid;
    logic              busy;
    logic              err;
    logic [CNT_W-1:0]  rd_count;
    logic [CNT_W-1:0]  wr_count;

    modport master (
        output a, read, write, wd,
        input  rd, valid, busy, err, rd_count, wr_count
    );

    modport slave (
        input  a, read, write, wd,
        output rd, valid, busy, err, rd_count, wr_count
    );
endinterface

// File: rtl/mm_responder.sv
// Main-memory responder: 256-bit line storage, fixed-latency in-order read returns,
// bounded outstanding-read queue with back-pressure and a sticky protocol error flag.
module mm_responder #(
    parameter int unsigned MEM_RANGE    = 256,
    parameter int unsigned READ_LATENCY = 4,
    parameter int unsigned DEPTH        = 2
) (
    input logic           clk,
    input logic           reset,
    mm_responder_if.slave bus
);
    localparam int unsigned AW     = $clog2(MEM_RANGE);
    localparam int unsigned PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned OW     = $clog2(DEPTH + 1);
    localparam int unsigned LW     = 4;
    localparam int unsigned LINE_W = 256;
    localparam int unsigned CNT_W  = 16;

    logic [LINE_W-1:0] r_mem   [MEM_RANGE];
    logic [LINE_W-1:0] r_fdata [DEPTH];
    logic [LW-1:0]     r_fcnt  [DEPTH];
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [OW-1:0]     r_occ;
    logic [LINE_W-1:0] r_rd;
    logic              r_valid;
    logic              r_busy;
    logic              r_err;
    logic [CNT_W-1:0]  r_rd_count;
    logic [CNT_W-1:0]  r_wr_count;

    logic [AW-1:0]     w_idx;
    logic              w_accept;
    logic              w_pop;
    logic [OW-1:0]     w_occ_next;
    logic              w_unused_addr;

    function automatic logic [LINE_W-1:0] f_line_init(input int unsigned line);
        logic [LINE_W-1:0] v;
        v = '0;
        for (int unsigned j = 0; j < 8; j++) begin
            v[32*j +: 32] = {16'(line), 13'd0, 3'(j)};
        end
        return v;
    endfunction

    function automatic logic [PW-1:0] f_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_idx         = bus.a[5 +: AW];
    assign w_unused_addr = ^{bus.a[31:5+AW], bus.a[4:0]};
    assign w_accept      = bus.read & ~bus.write & ~r_busy;
    // Entries are pushed in order with identical latency, so only the head can be due.
    assign w_pop         = (r_occ != '0) && (r_fcnt[r_head] == '0);
    assign w_occ_next    = r_occ + OW'(w_accept) - OW'(w_pop);

    // Line storage; reset restores the address-derived pattern.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < MEM_RANGE; i++) begin
                r_mem[i] <= f_line_init(i);
            end
        end else if (bus.write) begin
            r_mem[w_idx] <= bus.wd;
        end
    end

    // Read data is captured at acceptance so later writes cannot alter it.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_fdata[r_tail] <= r_mem[w_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_occ      <= '0;
            r_rd       <= '0;
            r_valid    <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
            r_rd_count <= '0;
            r_wr_count <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                r_fcnt[k] <= '0;
            end
        end else begin
            for (int unsigned k = 0; k < DEPTH; k++) begin
                if (r_fcnt[k] != '0) begin
                    r_fcnt[k] <= r_fcnt[k] - LW'(1);
                end
            end
            if (w_accept) begin
                r_fcnt[r_tail] <= LW'(READ_LATENCY - 1);
                r_tail         <= f_next(r_tail);
                r_rd_count     <= r_rd_count + CNT_W'(1);
            end
            if (w_pop) begin
                r_head <= f_next(r_head);
            end
            if (bus.write) begin
                r_wr_count <= r_wr_count + CNT_W'(1);
            end
            if (bus.read && (bus.write || r_busy)) begin
                r_err <= 1'b1;
            end
            r_valid <= w_pop;
            r_rd    <= w_pop ? r_fdata[r_head] : '0;
            r_occ   <= w_occ_next;
            r_busy  <= (w_occ_next == OW'(DEPTH));
        end
    end

    assign bus.rd       = r_rd;
    assign bus.valid    = r_valid;
    assign bus.busy     = r_busy;
    assign bus.err      = r_err;
    assign bus.rd_count = r_rd_count;
    assign bus.wr_count = r_wr_count;
endmodule

// File: tb/tb_mm_responder.sv
// Randomized and directed bench for mm_responder against a due-time queue reference model.
module tb_mm_responder;
    localparam int unsigned MEM_RANGE = 256;
    localparam int unsigned L         = 4;
    localparam int unsigned D         = 2;

    typedef struct packed {
        logic         rst;
        logic         r;
        logic         w;
        logic [31:0]  a;
        logic [255:0] wd;
    } stim_t;

    typedef struct {
        int           due;
        logic [255:0] data;
    } pend_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    mm_responder_if bus();

    mm_responder #(.MEM_RANGE(MEM_RANGE), .READ_LATENCY(L), .DEPTH(D)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state: expected outputs after the most recent edge.
    logic [255:0] m_mem [MEM_RANGE];
    pend_t        pend [$];
    int           m_edge = 0;
    logic         e_valid = 1'b0;
    logic         e_busy = 1'b0;
    logic         e_err = 1'b0;
    logic [15:0]  e_rc = '0;
    logic [15:0]  e_wc = '0;
    logic [255:0] e_rd = '0;
    stim_t        stim [$];

    function automatic void model_step(input stim_t s);
        int    idx;
        pend_t p;
        m_edge++;
        if (s.rst) begin
            pend.delete();
            for (int i = 0; i < int'(MEM_RANGE); i++)
                for (int j = 0; j < 8; j++)
                    m_mem[i][32*j +: 32] = (i << 16) | j;
            {e_valid, e_busy, e_err, e_rc, e_wc, e_rd} = '0;
            return;
        end
        e_valid = 1'b0;
        e_rd    = '0;
        if (pend.size() > 0 && pend[0].due == m_edge) begin
            e_valid = 1'b1;
            e_rd    = pend[0].data;
            void'(pend.pop_front());
        end
        idx = int'((s.a >> 5) % MEM_RANGE);
        if (s.r && (s.w || e_busy)) begin
            e_err = 1'b1;
        end else if (s.r) begin
            p.due  = m_edge + int'(L);
            p.data = m_mem[idx];
            pend.push_back(p);
            e_rc++;
        end
        if (s.w) begin
            m_mem[idx] = s.wd;
            e_wc++;
        end
        e_busy = (pend.size() == int'(D));
    endfunction

    function automatic string got_str();
        return $sformatf("v%b b%b e%b rc%0d wc%0d rd=%h", bus.valid, bus.busy, bus.err,
                         bus.rd_count, bus.wr_count, bus.rd);
    endfunction

    function automatic string exp_str();
        return $sformatf("v%b b%b e%b rc%0d wc%0d rd=%h", e_valid, e_busy, e_err, e_rc, e_wc, e_rd);
    endfunction

    function automatic void add(input logic rst, input logic r, input logic w,
                                input logic [31:0] a, input logic [255:0] wd);
        stim_t s;
        s.rst = rst; s.r = r; s.w = w; s.a = a; s.wd = wd;
        stim.push_back(s);
    endfunction

    function automatic void add_idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 32'h0, '0);
    endfunction

    function automatic logic [31:0] line_a(input int line);
        return 32'(line) << 5;
    endfunction

    function automatic logic [255:0] rand_line();
        logic [255:0] v;
        for (int j = 0; j < 8; j++) v[32*j +: 32] = $urandom;
        return v;
    endfunction

    task automatic cycle(input stim_t s);
        @(negedge clk);
        reset     = s.rst;
        bus.read  = s.r;
        bus.write = s.w;
        bus.a     = s.a;
        bus.wd    = s.wd;
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic test_reset();
        stim.delete();
        add(1'b1, 1'b0, 1'b0, 32'h0, '0);
        add(1'b1, 1'b1, 1'b1, 32'h60, '1);
        add_idle(2);
        for (int i = 0; i < stim.size(); i++) begin
            cycle(stim[i]);
            n_vec++;
            if ({bus.valid, bus.busy, bus.err, bus.rd_count, bus.wr_count, bus.rd} !==
                {e_valid, e_busy, e_err, e_rc, e_wc, e_rd}) begin
                n_bad++; $display("FAIL reset[%0d]: got %s exp %s", i, got_str(), exp_str());
            end
            n_vec++;
            if ({bus.valid, bus.busy, bus.err, bus.rd_count, bus.wr_count, bus.rd} !== '0) begin
                n_bad++; $display("FAIL reset_zero[%0d]: got %s exp all zero", i, got_str());
            end
        end
    endtask

    task automatic test_read_latency();
        int pulses = 0;
        stim.delete();
        add(1'b1, 1'b0, 1'b0, 32'h0, '0);
        add(1'b0, 1'b1, 1'b0, 32'h0000_0060, '0);
        add_idle(7);
        for (int i = 0; i < stim.size(); i++) begin
            cycle(stim[i]);
            n_vec++;
            if ({bus.valid, bus.busy, bus.err, bus.rd_count, bus.wr_count, bus.rd} !==
                {e_valid, e_busy, e_err, e_rc, e_wc, e_rd}) begin
                n_bad++; $display("FAIL read_latency[%0d]: got %s exp %s", i, got_str(), exp_str());
            end
            if (bus.valid === 1'b1) pulses++;
            n_vec++;
            if (bus.valid !== (i == 5)) begin
                n_bad++; $display("FAIL read_latency_edge[%0d]: got valid=%b exp %b", i, bus.valid, i == 5);
            end
            if (i == 5) begin
                n_vec++;
                if (bus.rd[95:64] !== 32'h0003_0002 || bus.rd[31:0] !== 32'h0003_0000) begin
                    n_bad++; $display("FAIL read_latency_data: got %h/%h exp 00030002/00030000",
                                      bus.rd[95:64], bus.rd[31:0]);
                end
            end
        end
        n_vec++;
        if (pulses != 1 || bus.rd_count !== 16'd1) begin
            n_bad++; $display("FAIL read_latency_count: got pulses=%0d rc=%0d exp 1/1", pulses, bus.rd_count);
        end
    endtask

    task automatic test_write_read();
        int pulses = 0;
        stim.delete();
        add(1'b1, 1'b0, 1'b0, 32'h0, '0);
        add(1'b0, 1'b0, 1'b1, line_a(5), {8{32'hDEAD_BEEF}});
        add(1'b0, 1'b1, 1'b0, 32'h0000_00A0, '0);
        add(1'b0, 1'b1, 1'b0, 32'h2000_00A0, '0);
        add_idle(6);
        for (int i = 0; i < stim.size(); i++) begin
            cycle(stim[i]);
            n_vec++;
            if ({bus.valid, bus.busy, bus.err, bus.rd_count, bus.wr_count, bus.rd} !==
                {e_valid, e_busy, e_err, e_rc, e_wc, e_rd}) begin
                n_bad++; $display("FAIL write_read[%0d]: got %s exp %s", i, got_str(), exp_str());
            end
            if (bus.valid === 1'b1) begin
                pulses++;
                n_vec++;
                if (bus.rd !== {8{32'hDEAD_BEEF}}) begin
                    n_bad++; $display("FAIL write_read_data[%0d]: got %h exp DEADBEEF x8", i, bus.rd);
                end
            end
        end
        n_vec++;
        if (pulses != 2 || bus.wr_count !== 16'd1) begin
            n_bad++; $display("FAIL write_read_count: got pulses=%0d wc=%0d exp 2/1", pulses, bus.wr_count);
        end
    endtask

    task automatic test_busy();
        int pulses = 0;
        stim.delete();
        add(1'b1, 1'b0, 1'b0, 32'h0, '0);
        for (int k = 1; k <= 3; k++) add(1'b0, 1'b1, 1'b0, line_a(k), '0);
        add_idle(7);
        for (int i = 0; i < stim.size(); i++) begin
            cycle(stim[i]);
            n_vec++;
            if ({bus.valid, bus.busy, bus.err, bus.rd_count, bus.wr_count, bus.rd} !==
                {e_valid, e_busy, e_err, e_rc, e_wc, e_rd}) begin
                n_bad++; $display("FAIL busy[%0d]: got %s exp %s", i, got_str(), exp_str());
            end
            if (bus.valid === 1'b1) pulses++;
            if (i == 2 || i == 3) begin
                n_vec++;
                if (bus.busy !== 1'b1 || bus.err !== (i == 3)) begin
                    n_bad++; $display("FAIL busy_flag[%0d]: got busy=%b err=%b exp 1/%b", i, bus.busy, bus.err, i == 3);
                end
            end
        end
        n_vec++;
        if (pulses != 2 || bus.rd_count !== 16'd2 || bus.err !== 1'b1) begin
            n_bad++; $display("FAIL busy_count: got pulses=%0d rc=%0d err=%b exp 2/2/1", pulses, bus.rd_count, bus.err);
        end
    endtask

    task automatic test_snapshot();
        stim.delete();
        add(1'b1, 1'b0, 1'b0, 32'h0, '0);
        add(1'b0, 1'b1, 1'b0, line_a(7), '0);
        add(1'b0, 1'b0, 1'b1, line_a(7), '1);
        add_idle(4);
        add(1'b0, 1'b1, 1'b0, line_a(7), '0);
        add_idle(5);
        for (int i = 0; i < stim.size(); i++) begin
            cycle(stim[i]);
            n_vec++;
            if ({bus.valid, bus.busy, bus.err, bus.rd_count, bus.wr_count, bus.rd} !==
                {e_valid, e_busy, e_err, e_rc, e_wc, e_rd}) begin
                n_bad++; $display("FAIL snapshot[%0d]: got %s exp %s", i, got_str(), exp_str());
            end
            if (i == 5 || i == 11) begin
                n_vec++;
                if (bus.valid !== 1'b1 ||
                    (i == 5 && bus.rd[31:0] !== 32'h0007_0000) ||
                    (i == 11 && bus.rd !== {256{1'b1}})) begin
                    n_bad++; $display("FAIL snapshot_data[%0d]: got v=%b rd=%h", i, bus.valid, bus.rd);
                end
            end
        end
    endtask

    task automatic test_rw_conflict();
        int pulses = 0;
        stim.delete();
        add(1'b1, 1'b0, 1'b0, 32'h0, '0);
        add(1'b0, 1'b1, 1'b1, line_a(1), '0);
        add_idle(5);
        add(1'b0, 1'b1, 1'b0, line_a(1), '0);
        add_idle(5);
        for (int i = 0; i < stim.size(); i++) begin
            cycle(stim[i]);
            n_vec++;
            if ({bus.valid, bus.busy, bus.err, bus.rd_count, bus.wr_count, bus.rd} !==
                {e_valid, e_busy, e_err, e_rc, e_wc, e_rd}) begin
                n_bad++; $display("FAIL rw_conflict[%0d]: got %s exp %s", i, got_str(), exp_str());
            end
            if (i <= 6 && bus.valid === 1'b1) pulses++;
            if (i == 6) begin
                n_vec++;
                if (pulses != 0 || bus.err !== 1'b1 || bus.wr_count !== 16'd1 || bus.rd_count !== 16'd0) begin
                    n_bad++; $display("FAIL rw_conflict_state: got pulses=%0d err=%b wc=%0d rc=%0d exp 0/1/1/0",
                                      pulses, bus.err, bus.wr_count, bus.rd_count);
                end
            end
            if (i == 11) begin
                n_vec++;
                if (bus.valid !== 1'b1 || bus.rd !== '0) begin
                    n_bad++; $display("FAIL rw_conflict_data: got v=%b rd=%h exp 1/zero", bus.valid, bus.rd);
                end
            end
        end
    endtask

    task automatic test_reset_inflight();
        stim.delete();
        add(1'b1, 1'b0, 1'b0, 32'h0, '0);
        add(1'b0, 1'b0, 1'b1, line_a(3), rand_line());
        add(1'b0, 1'b1, 1'b0, line_a(2), '0);
        add(1'b0, 1'b1, 1'b0, line_a(4), '0);
        add(1'b1, 1'b0, 1'b0, 32'h0, '0);
        add_idle(8);
        add(1'b0, 1'b1, 1'b0, 32'h0000_0060, '0);
        add_idle(5);
        for (int i = 0; i < stim.size(); i++) begin
            cycle(stim[i]);
            n_vec++;
            if ({bus.valid, bus.busy, bus.err, bus.rd_count, bus.wr_count, bus.rd} !==
                {e_valid, e_busy, e_err, e_rc, e_wc, e_rd}) begin
                n_bad++; $display("FAIL reset_inflight[%0d]: got %s exp %s", i, got_str(), exp_str());
            end
            if (i >= 4 && i <= 12) begin
                n_vec++;
                if ({bus.valid, bus.busy, bus.err, bus.rd_count, bus.wr_count} !== '0) begin
                    n_bad++; $display("FAIL reset_inflight_quiet[%0d]: got %s exp all zero", i, got_str());
                end
            end
            if (i == 17) begin
                n_vec++;
                if (bus.valid !== 1'b1 || bus.rd[31:0] !== 32'h0003_0000 || bus.rd[95:64] !== 32'h0003_0002) begin
                    n_bad++; $display("FAIL reset_inflight_data: got v=%b rd=%h", bus.valid, bus.rd);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        stim.delete();
        add(1'b1, 1'b0, 1'b0, 32'h0, '0);
        for (int k = 0; k < 12; k++) add(1'b0, 1'b1, 1'b0, $urandom, '0);
        add_idle(6);
        for (int i = 0; i < stim.size(); i++) begin
            cycle(stim[i]);
            n_vec++;
            if ({bus.valid, bus.busy, bus.err, bus.rd_count, bus.wr_count, bus.rd} !==
                {e_valid, e_busy, e_err, e_rc, e_wc, e_rd}) begin
                n_bad++; $display("FAIL back_to_back[%0d]: got %s exp %s", i, got_str(), exp_str());
            end
            if (i == 5 || i == 6) begin
                n_vec++;
                if (bus.valid !== 1'b1) begin
                    n_bad++; $display("FAIL back_to_back_pulse[%0d]: got valid=%b exp 1", i, bus.valid);
                end
            end
        end
    endtask

    task automatic test_random();
        stim.delete();
        add(1'b1, 1'b0, 1'b0, 32'h0, '0);
        for (int k = 0; k < 600; k++) begin
            add(($urandom % 80) == 0, ($urandom % 3) != 0, ($urandom % 4) == 0,
                {$urandom, 5'b0} ^ ($urandom % 2 ? 32'h0 : 32'h0000_0F00), rand_line());
        end
        add_idle(8);
        for (int i = 0; i < stim.size(); i++) begin
            cycle(stim[i]);
            n_vec++;
            if ({bus.valid, bus.busy, bus.err, bus.rd_count, bus.wr_count, bus.rd} !==
                {e_valid, e_busy, e_err, e_rc, e_wc, e_rd}) begin
                n_bad++; $display("FAIL random[%0d]: got %s exp %s", i, got_str(), exp_str());
            end
        end
    endtask

    initial begin
        bus.read  = 1'b0;
        bus.write = 1'b0;
        bus.a     = '0;
        bus.wd    = '0;
        test_reset();
        test_read_latency();
        test_write_read();
        test_busy();
        test_snapshot();
        test_rw_conflict();
        test_reset_inflight();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
